// File: rtl/lcd_byte_writer.sv
// Byte-to-nibble writer for a 4-bit HD44780 LCD bus. It runs the power-on init sequence
// by itself, then serialises each accepted byte as two timed E pulses.
module lcd_byte_writer #(
  parameter int P_SETUP      = 2,
  parameter int P_E_PULSE    = 12,
  parameter int P_NIBBLE_GAP = 50,
  parameter int P_CHAR_WAIT  = 2000,
  parameter int P_CLEAR_WAIT = 82000,
  parameter int P_POWERUP    = 750000,
  parameter int P_INIT_WAIT1 = 205000,
  parameter int P_INIT_WAIT2 = 5000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data,
  output logic [3:0] oDebugState
);

  // Handshake: a byte transfers on the rising edge where iValid && oReady; oReady is high
  // only in IDLE, iData/iRS are captured on that edge, and iValid at any other time is ignored.
  typedef enum logic [3:0] {
    S_PWRUP, S_INIT_NIB, S_INIT_WAIT, S_INIT_BYTE, S_IDLE,
    S_HI_NIB, S_GAP, S_LO_NIB, S_SETTLE
  } state_t;

  localparam logic [19:0] L_NIB   = 20'(P_SETUP + P_E_PULSE - 1);
  localparam logic [19:0] L_EP    = 20'(P_E_PULSE);
  localparam logic [19:0] L_GAP   = 20'(P_NIBBLE_GAP - 1);
  localparam logic [19:0] L_CHAR  = 20'(P_CHAR_WAIT - 1);
  localparam logic [19:0] L_CLEAR = 20'(P_CLEAR_WAIT - 1);
  localparam logic [19:0] L_W1    = 20'(P_INIT_WAIT1 - 1);
  localparam logic [19:0] L_W2    = 20'(P_INIT_WAIT2 - 1);
  // The counter leaves reset at 0 and wraps downward during power-up, so power-up ends
  // when it has decremented P_POWERUP-1 times.
  localparam logic [19:0] L_PWRUP_END = 20'(1048576 - (P_POWERUP - 1));

  state_t      r_state, w_state_nxt;
  logic [19:0] r_cnt, w_cnt_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_rs, w_rs_nxt;
  logic [3:0]  r_db, w_db_nxt;
  logic [1:0]  r_init_idx, w_init_idx_nxt;
  logic [1:0]  r_byte_idx, w_byte_idx_nxt;
  logic        r_e, w_e_nxt;
  logic        r_ready;
  logic        r_init_done;
  logic        w_done;
  logic        w_is_clear;
  logic [19:0] w_init_wait;
  logic [7:0]  w_init_byte;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt - 20'd1;
    w_data_nxt     = r_data;
    w_rs_nxt       = r_rs;
    w_db_nxt       = r_db;
    w_init_idx_nxt = r_init_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_done         = (r_cnt == 20'd0);
    w_is_clear     = !r_rs && (r_data == 8'h01 || r_data == 8'h02 || r_data == 8'h03);
    w_init_byte    = init_byte(r_byte_idx);
    case (r_init_idx)
      2'd0:    w_init_wait = L_W1;
      2'd1:    w_init_wait = L_W2;
      default: w_init_wait = L_CHAR;
    endcase

    case (r_state)
      S_PWRUP: begin
        if (r_cnt == L_PWRUP_END) begin
          w_state_nxt = S_INIT_NIB;
          w_cnt_nxt   = L_NIB;
          w_db_nxt    = 4'h3;
          w_rs_nxt    = 1'b0;
        end
      end
      S_INIT_NIB: begin
        if (w_done) begin
          w_state_nxt = S_INIT_WAIT;
          w_cnt_nxt   = w_init_wait;
        end
      end
      S_INIT_WAIT: begin
        if (w_done) begin
          if (r_init_idx == 2'd3) begin
            w_state_nxt = S_INIT_BYTE;
            w_cnt_nxt   = 20'd0;
          end else begin
            w_init_idx_nxt = r_init_idx + 2'd1;
            w_state_nxt    = S_INIT_NIB;
            w_cnt_nxt      = L_NIB;
            w_db_nxt       = (r_init_idx == 2'd2) ? 4'h2 : 4'h3;
          end
        end
      end
      S_INIT_BYTE: begin
        w_state_nxt = S_HI_NIB;
        w_cnt_nxt   = L_NIB;
        w_data_nxt  = w_init_byte;
        w_rs_nxt    = 1'b0;
        w_db_nxt    = w_init_byte[7:4];
      end
      S_IDLE: begin
        w_cnt_nxt = 20'd0;
        if (iValid) begin
          w_state_nxt = S_HI_NIB;
          w_cnt_nxt   = L_NIB;
          w_data_nxt  = iData;
          w_rs_nxt    = iRS;
          w_db_nxt    = iData[7:4];
        end
      end
      S_HI_NIB: begin
        if (w_done) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = L_GAP;
        end
      end
      S_GAP: begin
        if (w_done) begin
          w_state_nxt = S_LO_NIB;
          w_cnt_nxt   = L_NIB;
          w_db_nxt    = r_data[3:0];
        end
      end
      S_LO_NIB: begin
        if (w_done) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = w_is_clear ? L_CLEAR : L_CHAR;
        end
      end
      S_SETTLE: begin
        if (w_done) begin
          w_cnt_nxt = 20'd0;
          if (r_init_done || r_byte_idx == 2'd3) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_state_nxt    = S_INIT_BYTE;
          end
        end
      end
      default: begin
        w_state_nxt = S_PWRUP;
        w_cnt_nxt   = 20'd0;
      end
    endcase

    // A nibble phase spends its first P_SETUP counts with E low and the last P_E_PULSE high.
    w_e_nxt = (w_state_nxt == S_INIT_NIB || w_state_nxt == S_HI_NIB || w_state_nxt == S_LO_NIB)
              && (w_cnt_nxt < L_EP);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state     <= S_PWRUP;
      r_cnt       <= 20'd0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_db        <= 4'h0;
      r_init_idx  <= 2'd0;
      r_byte_idx  <= 2'd0;
      r_e         <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data      <= w_data_nxt;
      r_rs        <= w_rs_nxt;
      r_db        <= w_db_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_e         <= w_e_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_init_done <= r_init_done | (w_state_nxt == S_IDLE);
    end
  end

  assign oReady                  = r_ready;
  assign oInitDone               = r_init_done;
  assign oLCD_Enabled            = r_e;
  assign oLCD_RegisterSelect     = r_rs;
  assign oLCD_Data               = r_db;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;
  assign oDebugState             = r_state;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: init sequence, byte timing, commands, back-to-back and abort,
// with every E pulse checked against an expected {RS,DB} queue.
module tb_lcd_byte_writer;

  localparam int S = 2, EP = 4, G = 3, CW = 10, CLW = 40, PU = 20, W1 = 15, W2 = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_rs = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready, o_init_done, e, rs, rw, sf;
  logic [3:0] db, dbg;

  lcd_byte_writer #(
    .P_SETUP(S), .P_E_PULSE(EP), .P_NIBBLE_GAP(G), .P_CHAR_WAIT(CW),
    .P_CLEAR_WAIT(CLW), .P_POWERUP(PU), .P_INIT_WAIT1(W1), .P_INIT_WAIT2(W2)
  ) dut (
    .Clock(clk), .Reset(rst_n), .iData(i_data), .iRS(i_rs), .iValid(i_valid),
    .oReady(o_ready), .oInitDone(o_init_done), .oLCD_Enabled(e),
    .oLCD_RegisterSelect(rs), .oLCD_ReadWrite(rw), .oLCD_StrataFlashControl(sf),
    .oLCD_Data(db), .oDebugState(dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Scoreboard: each E rising edge must carry the next expected {RS,DB}.
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;
  logic [4:0] held;
  bit         mon_en = 0;
  bit         skip_width = 0;
  bit         prev_e = 0;
  int         pulse_cnt = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;

  always @(negedge clk) begin
    checks++;
    if (rw !== 1'b0 || sf !== 1'b1) begin
      errors++;
      $display("FAIL const_pins rw=%b sf=%b required rw=0 sf=1", rw, sf);
    end
    if (mon_en) begin
      if (e === 1'b1 && !prev_e) begin
        pulse_cnt++;
        rise_cyc = cyc;
        held = {rs, db};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected got rs=%b db=%h required no pulse", rs, db);
        end else begin
          exp_v = exp_q.pop_front();
          if ({rs, db} !== exp_v) begin
            errors++;
            $display("FAIL pulse_data got rs=%b db=%h required rs=%b db=%h",
                     rs, db, exp_v[4], exp_v[3:0]);
          end
        end
      end else if (e === 1'b1 && prev_e) begin
        checks++;
        if ({rs, db} !== held) begin
          errors++;
          $display("FAIL bus_stable got rs=%b db=%h required rs=%b db=%h", rs, db, held[4], held[3:0]);
        end
      end else if (e !== 1'b1 && prev_e) begin
        fall_cyc = cyc;
        if (skip_width) skip_width = 0;
        else begin
          checks++;
          if (cyc - rise_cyc != EP) begin
            errors++;
            $display("FAIL e_width got %0d required %0d", cyc - rise_cyc, EP);
          end
        end
      end
      prev_e = (e === 1'b1);
    end
  end

  // Reference model: ready-to-ready latency of one byte.
  function automatic int exp_latency(input logic r, input logic [7:0] d);
    int w;
    w = (!r && d >= 8'h01 && d <= 8'h03) ? CLW : CW;
    return 2 * (S + EP) + G + w;
  endfunction

  function automatic void push_byte(input logic r, input logic [7:0] d);
    exp_q.push_back({r, d[7:4]});
    exp_q.push_back({r, d[3:0]});
  endfunction

  // Driver: releases reset (caller stands at a negedge) and follows the init sequence.
  task automatic release_and_init(output int rise_n, output logic [4:0] rise_bus,
                                  output int done_gap, output logic rdy_at_done,
                                  output int early_rdy, output bit tmo);
    logic [7:0] init_bytes[4];
    bit got;
    init_bytes = '{8'h28, 8'h06, 8'h0C, 8'h01};
    exp_q.push_back(5'h03); exp_q.push_back(5'h03);
    exp_q.push_back(5'h03); exp_q.push_back(5'h02);
    for (int i = 0; i < 4; i++) push_byte(1'b0, init_bytes[i]);
    tmo = 0; rise_n = -1; rise_bus = 'x; done_gap = -1; rdy_at_done = 1'bx; early_rdy = 0;
    rst_n = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (e === 1'b1) begin
        rise_n = n;
        rise_bus = {rs, db};
        break;
      end
    end
    if (rise_n < 0) begin tmo = 1; return; end
    got = 0;
    for (int n = 0; n < 5000 && !got; n++) begin
      @(negedge clk);
      if (o_ready === 1'b1 && o_init_done !== 1'b1) early_rdy++;
      if (o_init_done === 1'b1) got = 1;
    end
    if (!got) begin tmo = 1; return; end
    done_gap = cyc - fall_cyc;
    rdy_at_done = o_ready;
  endtask

  // Driver: one handshake; reports ready-to-ready latency and oReady right after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic r, output int lat,
                           output logic rdy_after, output bit tmo);
    int acc;
    bit got;
    tmo = 0; lat = -1; rdy_after = 1'bx;
    push_byte(r, d);
    @(posedge clk); #1;
    i_data = d; i_rs = r; i_valid = 1'b1;
    got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (o_ready === 1'b1) got = 1;
    end
    if (!got) begin tmo = 1; i_valid = 1'b0; return; end
    @(posedge clk); #1;
    acc = cyc;
    i_valid = 1'b0; i_data = 8'($urandom); i_rs = 1'($urandom);
    @(negedge clk);
    rdy_after = o_ready;
    got = (o_ready === 1'b1);
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (o_ready === 1'b1) got = 1;
    end
    if (!got) begin tmo = 1; return; end
    lat = cyc - acc;
  endtask

  task automatic test_reset();
    int rise_n, done_gap, early, base;
    logic [4:0] rise_bus;
    logic rdy;
    bit tmo;
    rst_n = 1'b0; i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({e, rs, db, o_ready, o_init_done} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got e=%b rs=%b db=%h rdy=%b done=%b required all 0",
               e, rs, db, o_ready, o_init_done);
    end
    mon_en = 1;
    base = pulse_cnt;
    release_and_init(rise_n, rise_bus, done_gap, rdy, early, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL init_timeout got timeout required completion"); end
    checks++;
    if (rise_n != PU + S) begin errors++; $display("FAIL first_e_rise got %0d required %0d", rise_n, PU + S); end
    checks++;
    if (rise_bus !== 5'h03) begin errors++; $display("FAIL first_nibble got %h required 03", rise_bus); end
    checks++;
    if (done_gap != CLW) begin errors++; $display("FAIL init_clear_wait got %0d required %0d", done_gap, CLW); end
    checks++;
    if (rdy !== 1'b1 || early != 0) begin
      errors++;
      $display("FAIL ready_with_done got rdy=%b early=%0d required rdy=1 early=0", rdy, early);
    end
    checks++;
    if (pulse_cnt - base != 12 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL init_pulses got %0d left=%0d required 12 left=0", pulse_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_char();
    int lat;
    logic ra, r;
    logic [7:0] d;
    bit tmo;
    send_byte(8'h41, 1'b1, lat, ra, tmo);
    checks++;
    if (tmo || lat != 25) begin errors++; $display("FAIL char_41_latency got %0d tmo=%0d required 25", lat, tmo); end
    checks++;
    if (ra !== 1'b0) begin errors++; $display("FAIL ready_drop got %b required 0", ra); end
    send_byte(8'h02, 1'b1, lat, ra, tmo);
    checks++;
    if (tmo || lat != 25) begin errors++; $display("FAIL char_02_latency got %0d required 25", lat); end
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 2) d = 8'($urandom_range(1, 3));
      r = 1'($urandom);
      send_byte(d, r, lat, ra, tmo);
      checks++;
      if (tmo || lat != exp_latency(r, d)) begin
        errors++;
        $display("FAIL rand_latency d=%h rs=%b got %0d required %0d", d, r, lat, exp_latency(r, d));
      end
    end
  endtask

  task automatic test_cmd();
    logic [7:0] cmds[6];
    int lat;
    logic ra;
    bit tmo;
    cmds = '{8'h01, 8'h80, 8'h02, 8'h03, 8'h00, 8'h04};
    for (int i = 0; i < 6; i++) begin
      send_byte(cmds[i], 1'b0, lat, ra, tmo);
      checks++;
      if (tmo || lat != exp_latency(1'b0, cmds[i])) begin
        errors++;
        $display("FAIL cmd_latency d=%h got %0d required %0d", cmds[i], lat, exp_latency(1'b0, cmds[i]));
      end
    end
    checks++;
    if (exp_latency(1'b0, 8'h01) != 55 || exp_latency(1'b0, 8'h80) != 25) begin
      errors++;
      $display("FAIL model_constants got %0d/%0d required 55/25", exp_latency(1'b0, 8'h01), exp_latency(1'b0, 8'h80));
    end
  endtask

  task automatic test_back_to_back();
    int base, acc1, acc2, r1, lat2;
    bit got;
    base = pulse_cnt;
    push_byte(1'b1, 8'h48);
    push_byte(1'b1, 8'h49);
    @(posedge clk); #1;
    i_data = 8'h48; i_rs = 1'b1; i_valid = 1'b1;
    got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin @(negedge clk); if (o_ready === 1'b1) got = 1; end
    @(posedge clk); #1;
    acc1 = cyc;
    i_data = 8'h49;
    got = 0; r1 = -1;
    for (int n = 0; n < 2000 && !got; n++) begin @(negedge clk); if (o_ready === 1'b1) got = 1; end
    if (got) r1 = cyc;
    checks++;
    if (r1 - acc1 != 25) begin errors++; $display("FAIL b2b_first_latency got %0d required 25", r1 - acc1); end
    @(posedge clk); #1;
    acc2 = cyc;
    i_data = 8'($urandom); i_rs = 1'($urandom);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got rdy=%b required 0", o_ready); end
    for (int i = 0; i < 25 - 4; i++) begin
      @(posedge clk); #1;
      i_valid = 1'($urandom_range(0, 1));
      i_data = 8'($urandom); i_rs = 1'($urandom);
    end
    i_valid = 1'b0;
    got = 0; lat2 = -1;
    for (int n = 0; n < 2000 && !got; n++) begin @(negedge clk); if (o_ready === 1'b1) got = 1; end
    if (got) lat2 = cyc - acc2;
    checks++;
    if (lat2 != 25) begin errors++; $display("FAIL b2b_second_latency got %0d required 25", lat2); end
    checks++;
    if (pulse_cnt - base != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pulse_count got %0d left=%0d required 4 left=0", pulse_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int base, rise_n, done_gap, early, lat;
    logic [4:0] rise_bus;
    logic rdy, ra;
    logic [7:0] d;
    bit tmo, got;
    base = pulse_cnt;
    d = 8'($urandom_range(0, 255));
    push_byte(1'b1, d);
    @(posedge clk); #1;
    i_data = d; i_rs = 1'b1; i_valid = 1'b1;
    got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin @(negedge clk); if (o_ready === 1'b1) got = 1; end
    @(posedge clk); #1;
    i_valid = 1'b0;
    got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin @(negedge clk); if (pulse_cnt == base + 2) got = 1; end
    checks++;
    if (!got || e !== 1'b1) begin errors++; $display("FAIL abort_reach_lo got e=%b required 1", e); end
    rst_n = 1'b0;
    skip_width = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({e, rs, db, o_ready, o_init_done} !== 8'h00) begin
      errors++;
      $display("FAIL abort_outputs got e=%b rs=%b db=%h rdy=%b done=%b required all 0",
               e, rs, db, o_ready, o_init_done);
    end
    exp_q.delete();
    base = pulse_cnt;
    release_and_init(rise_n, rise_bus, done_gap, rdy, early, tmo);
    checks++;
    if (tmo || rise_n != PU + S || rise_bus !== 5'h03) begin
      errors++;
      $display("FAIL reinit_first_rise got n=%0d bus=%h tmo=%0d required n=%0d bus=03", rise_n, rise_bus, tmo, PU + S);
    end
    checks++;
    if (done_gap != CLW || rdy !== 1'b1 || pulse_cnt - base != 12) begin
      errors++;
      $display("FAIL reinit_done got gap=%0d rdy=%b pulses=%0d required gap=%0d rdy=1 pulses=12",
               done_gap, rdy, pulse_cnt - base, CLW);
    end
    send_byte(8'h03, 1'b0, lat, ra, tmo);
    checks++;
    if (tmo || lat != exp_latency(1'b0, 8'h03)) begin
      errors++;
      $display("FAIL post_abort_latency got %0d required %0d", lat, exp_latency(1'b0, 8'h03));
    end
  endtask

  initial begin
    test_reset();
    test_char();
    test_cmd();
    test_back_to_back();
    test_abort();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got %0d required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_byte_writer.md
Name: lcd_byte_writer

Overview:
Downstream consumer of the MiniAlu LCD instruction. It takes one byte per handshake (character or command) and drives the 4-bit HD44780-compatible LCD bus on the Spartan-3E board. It runs the mandatory power-on initialisation autonomously. It then serialises each accepted byte as two nibbles, with programmable setup, enable-pulse and settle timing.

Parameters:
P_SETUP, 2, cycles RS/DB stable with E low before each E pulse (40 ns @ 50 MHz)
P_E_PULSE, 12, cycles E held high per nibble (240 ns)
P_NIBBLE_GAP, 50, cycles between upper-nibble E fall and lower-nibble setup start (1 us)
P_CHAR_WAIT, 2000, settle cycles after a normal byte or an init nibble (40 us)
P_CLEAR_WAIT, 82000, settle cycles after command 0x01/0x02/0x03 (1.64 ms)
P_POWERUP, 750000, cycles after reset before first init nibble (15 ms)
P_INIT_WAIT1, 205000, settle after first init nibble (4.1 ms)
P_INIT_WAIT2, 5000, settle after second init nibble (100 us)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-low reset: Reset==0 at a rising Clock edge resets the block
iData  in  8  byte to send
iRS  in  1  1 = character data (RS=1), 0 = command
iValid  in  1  upstream has a byte
oReady  out  1  block can accept a byte this cycle
oInitDone  out  1  power-on init sequence complete (sticky until reset)
oLCD_Enabled  out  1  LCD E
oLCD_RegisterSelect  out  1  LCD RS
oLCD_ReadWrite  out  1  LCD RW, constant 0 (write only)
oLCD_StrataFlashControl  out  1  SF_CE0, constant 1 (StrataFlash disabled, bus owned by LCD)
oLCD_Data  out  4  LCD DB[7:4]

Behaviour:
- Reset (Reset==0 at edge): E=0, RS=0, RW=0, SF=1, DB=0, oReady=0, oInitDone=0, all counters 0, FSM=PWRUP. Reset mid-transfer aborts immediately; init restarts from PWRUP. No partial pulse is allowed to continue.
- All outputs are registered. A single 20-bit down-counter serves every wait. All parameters must be < 2^20.
- Nibble transfer (NIB):
  - DB and RS are driven at the first setup cycle.
  - E=0 for P_SETUP cycles, then E=1 for P_E_PULSE cycles, then E=0.
  - DB and RS hold their value until the next nibble's setup starts.
- Byte transfer:
  - Upper nibble iData[7:4] via NIB.
  - Then P_NIBBLE_GAP cycles with E=0.
  - Then lower nibble iData[3:0] via NIB.
  - Then settle for P_CLEAR_WAIT if RS=0 and data is in {0x01,0x02,0x03}, otherwise for P_CHAR_WAIT.
- FSM states: PWRUP, INIT_NIB, INIT_WAIT, INIT_BYTE, IDLE, HI_NIB, GAP, LO_NIB, SETTLE.
- Init sequence, all with RS=0:
  - Wait P_POWERUP.
  - Nibble 0x3, wait P_INIT_WAIT1.
  - Nibble 0x3, wait P_INIT_WAIT2.
  - Nibble 0x3, wait P_CHAR_WAIT.
  - Nibble 0x2, wait P_CHAR_WAIT.
  - Bytes 0x28, 0x06, 0x0C, 0x01, each via the byte path (0x01 settles with P_CLEAR_WAIT).
  - Then oInitDone=1, FSM=IDLE.
- Handshake:
  - oReady=1 only in IDLE.
  - A transfer occurs on the edge where iValid&&oReady. iData and iRS are captured into internal registers on that edge.
  - oReady=0 from the next cycle.
  - iValid while oReady=0 is ignored. There is no buffering; upstream holds iValid until accepted.
  - iData may change after acceptance without effect.
- Latency: oReady returns to 1 exactly T = 2*(P_SETUP+P_E_PULSE)+P_NIBBLE_GAP+W cycles after the acceptance edge, where W is the settle value selected above.
- Back-to-back: if iValid stays high, the next byte is accepted on the first cycle oReady=1. There is no idle bubble beyond that one cycle.
- RW and SF never change, including during reset.

Test Plan:
Use params SETUP=2, E_PULSE=4, GAP=3, CHAR_WAIT=10, CLEAR_WAIT=40, POWERUP=20, INIT_WAIT1=15, INIT_WAIT2=8 throughout.
1. Reset low 3 cycles then high -> all outputs at reset values. First E rise at cycle 20+2 with DB=0x3, RS=0. Nibble sequence 3,3,3,2 then bytes 28,06,0C,01. oInitDone and oReady rise together after the final 40-cycle clear wait.
2. After init, send iData=0x41, iRS=1 -> E pulses carry DB=0x4 then 0x1, RS=1 throughout, each E high exactly 4 cycles. oReady re-asserts 2*(2+4)+3+10=25 cycles after acceptance.
3. Send command 0x01, iRS=0 -> settle is 40 cycles and oReady returns after 55 cycles. Command 0x80 returns after 25 cycles.
4. Hold iValid=1 with 0x48 then 0x49 -> second byte accepted on the first oReady=1 cycle. Exactly 4 E pulses. iValid pulses during busy are ignored (E pulse count unchanged).
5. Assert Reset=0 mid lower nibble, while E=1 -> E=0 and oReady=0 on the next edge. The init sequence restarts from PWRUP; oInitDone=0.
6. Throughout all scenarios, oLCD_ReadWrite==0 and oLCD_StrataFlashControl==1. DB and RS never change while E=1.
